// File: rtl/cache_axi_bridge.sv
// Bridges the cache refill/writeback request interface onto an AXI4 master port.
// One refill (read) and one writeback (write) may be in flight at the same time;
// a read to a line that is being written back is held until the write completes.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   rd_req/rd_type/rd_addr/rd_rdy    cache read request
//   ret_valid/ret_last/ret_data      returned read words (pass-through of R)
//   wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy   cache write request
//   ar*/r*/aw*/w*/b*                 AXI4 master channels
module cache_axi_bridge #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned RD_ID = 0,
  parameter int unsigned WR_ID = 1
) (
  input  logic            clk,
  input  logic            rst,
  // cache read side
  input  logic            rd_req,
  input  logic [2:0]      rd_type,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic            ret_last,
  output logic [31:0]     ret_data,
  // cache write side
  input  logic            wr_req,
  input  logic [2:0]      wr_type,
  input  logic [31:0]     wr_addr,
  input  logic [3:0]      wr_wstrb,
  input  logic [127:0]    wr_data,
  output logic            wr_rdy,
  // AXI AR
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  // AXI R
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI AW
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  // AXI W
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI B
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  localparam logic [2:0] TYPE_LINE  = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_LINE   = 8'd3;
  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;

  r_state_e       r_state_q, r_state_d;
  logic [31:0]    rd_addr_q, rd_addr_d;
  logic [2:0]     rd_type_q, rd_type_d;

  w_state_e       w_state_q, w_state_d;
  logic [31:0]    wr_addr_q, wr_addr_d;
  logic [2:0]     wr_type_q, wr_type_d;
  logic [3:0]     wr_wstrb_q, wr_wstrb_d;
  logic [127:0]   wr_data_q, wr_data_d;
  logic [1:0]     wcnt_q, wcnt_d;

  logic           conflict_c;
  logic           rd_line_c;
  logic           wr_line_c;
  logic           unused_c;

  // Response codes carry no meaning for the cache; no error path exists.
  assign unused_c = ^{rresp, bresp};

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      rd_addr_q  <= '0;
      rd_type_q  <= '0;
      w_state_q  <= W_IDLE;
      wr_addr_q  <= '0;
      wr_type_q  <= '0;
      wr_wstrb_q <= '0;
      wr_data_q  <= '0;
      wcnt_q     <= '0;
    end else begin
      r_state_q  <= r_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_type_q  <= rd_type_d;
      w_state_q  <= w_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_type_q  <= wr_type_d;
      wr_wstrb_q <= wr_wstrb_d;
      wr_data_q  <= wr_data_d;
      wcnt_q     <= wcnt_d;
    end
  end

  // A read must not overtake a writeback of the same 16-byte line, either one
  // already in flight or one being accepted in this very cycle.
  assign conflict_c = ((w_state_q != W_IDLE) && (rd_addr[31:4] == wr_addr_q[31:4])) ||
                      (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));

  assign rd_rdy = (r_state_q == R_IDLE) && !conflict_c;
  assign wr_rdy = (w_state_q == W_IDLE);

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_type_d = rd_type_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_req && rd_rdy) begin
          r_state_d = R_AR;
          rd_addr_d = rd_addr;
          rd_type_d = rd_type;
        end
      end
      R_AR: begin
        if (arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid && rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state and beat counter
  always_comb begin
    w_state_d  = w_state_q;
    wr_addr_d  = wr_addr_q;
    wr_type_d  = wr_type_q;
    wr_wstrb_d = wr_wstrb_q;
    wr_data_d  = wr_data_q;
    wcnt_d     = wcnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_req) begin
          w_state_d  = W_AW;
          wr_addr_d  = wr_addr;
          wr_type_d  = wr_type;
          wr_wstrb_d = wr_wstrb;
          wr_data_d  = wr_data;
        end
      end
      W_AW: begin
        if (awready) begin
          w_state_d = W_DATA;
          wcnt_d    = 2'd0;
        end
      end
      W_DATA: begin
        if (wready) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign rd_line_c = (rd_type_q == TYPE_LINE);
  assign wr_line_c = (wr_type_q == TYPE_LINE);

  // AR channel, driven from the latched request
  assign arid    = ID_W'(RD_ID);
  assign araddr  = rd_addr_q;
  assign arlen   = rd_line_c ? LEN_LINE : LEN_SINGLE;
  assign arsize  = rd_line_c ? SIZE_WORD : {1'b0, rd_type_q[1:0]};
  assign arburst = BURST_INCR;
  assign arvalid = (r_state_q == R_AR);

  // R channel; returned words go straight back to the cache
  assign rready    = (r_state_q == R_DATA);
  assign ret_valid = rvalid && (r_state_q == R_DATA);
  assign ret_last  = rlast;
  assign ret_data  = rdata;

  // AW channel
  assign awid    = ID_W'(WR_ID);
  assign awaddr  = wr_addr_q;
  assign awlen   = wr_line_c ? LEN_LINE : LEN_SINGLE;
  assign awsize  = wr_line_c ? SIZE_WORD : {1'b0, wr_type_q[1:0]};
  assign awburst = BURST_INCR;
  assign awvalid = (w_state_q == W_AW);

  // W channel; word cnt of the latched line, lowest word first
  assign wdata  = wr_data_q[{wcnt_q, 5'd0} +: 32];
  assign wstrb  = wr_line_c ? 4'hf : wr_wstrb_q;
  assign wlast  = (wcnt_q == awlen[1:0]);
  assign wvalid = (w_state_q == W_DATA);

  // B channel
  assign bready = (w_state_q == W_RESP);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed self-checking bench for cache_axi_bridge.
module tb_cache_axi_bridge;

  logic         clk;
  logic         rst;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int n_checks;
  int n_fail;

  cache_axi_bridge #(.ID_W(4), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if ({arvalid, rready, awvalid, wvalid, bready, ret_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_valids got %b want 000000", {arvalid, rready, awvalid, wvalid, bready, ret_valid});
    end
    n_checks++; if ({rd_rdy, wr_rdy} !== 2'b11) begin
      n_fail++; $display("FAIL reset_rdy got %b want 11", {rd_rdy, wr_rdy});
    end
  endtask

  task automatic test_line_read();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0040;
    #1;
    n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_accept got %b want 1", rd_rdy); end
    tick();
    rd_req = 1'b0;
    #1;
    n_checks++; if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, 32'h1C00_0040, 8'd3, 3'd2, 2'b01, 4'd0}) begin
      n_fail++; $display("FAIL ar_line got v=%b a=%h l=%0d s=%0d b=%0d id=%0d want v=1 a=1c000040 l=3 s=2 b=1 id=0",
                         arvalid, araddr, arlen, arsize, arburst, arid);
    end
    n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL rd_busy got %b want 0", rd_rdy); end
    tick();
    tick();
    n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h1C00_0040}) begin
      n_fail++; $display("FAIL ar_hold got v=%b a=%h want v=1 a=1c000040", arvalid, araddr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    n_checks++; if ({arvalid, rready} !== 2'b01) begin
      n_fail++; $display("FAIL r_enter got arvalid/rready=%b want 01", {arvalid, rready});
    end
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b0;
      #1;
      n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL ret_gap%0d got %b want 0", i, ret_valid); end
      tick();
      rvalid = 1'b1; rdata = 32'hA0 + 32'(i); rlast = (i == 3);
      #1;
      n_checks++; if ({ret_valid, ret_last, ret_data} !== {1'b1, (i == 3), 32'hA0 + 32'(i)}) begin
        n_fail++; $display("FAIL ret_beat%0d got v=%b l=%b d=%h want v=1 l=%b d=%h",
                           i, ret_valid, ret_last, ret_data, (i == 3), 32'hA0 + 32'(i));
      end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_checks++; if ({rd_rdy, rready} !== 2'b10) begin
      n_fail++; $display("FAIL rd_done got rd_rdy/rready=%b want 10", {rd_rdy, rready});
    end
  endtask

  task automatic test_line_write();
    logic [31:0] exp_w;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_1230; wr_wstrb = 4'h0;
    wr_data = {32'h33, 32'h22, 32'h11, 32'h00};
    #1;
    n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_accept got %b want 1", wr_rdy); end
    tick();
    wr_req = 1'b0;
    #1;
    n_checks++; if ({awvalid, awaddr, awlen, awsize, awburst, awid} !== {1'b1, 32'h0000_1230, 8'd3, 3'd2, 2'b01, 4'd1}) begin
      n_fail++; $display("FAIL aw_line got v=%b a=%h l=%0d s=%0d b=%0d id=%0d want v=1 a=00001230 l=3 s=2 b=1 id=1",
                         awvalid, awaddr, awlen, awsize, awburst, awid);
    end
    n_checks++; if ({wr_rdy, wvalid} !== 2'b00) begin
      n_fail++; $display("FAIL wr_busy got wr_rdy/wvalid=%b want 00", {wr_rdy, wvalid});
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_w = 32'h11 * 32'(i);
      // Stall the slave once mid-burst; the beat must be held.
      if (i == 1) begin
        wready = 1'b0;
        tick();
      end
      wready = 1'b1;
      #1;
      n_checks++; if ({wvalid, wdata, wstrb, wlast} !== {1'b1, exp_w, 4'hf, (i == 3)}) begin
        n_fail++; $display("FAIL w_beat%0d got v=%b d=%h s=%h l=%b want v=1 d=%h s=f l=%b",
                           i, wvalid, wdata, wstrb, wlast, exp_w, (i == 3));
      end
      tick();
    end
    wready = 1'b0;
    #1;
    n_checks++; if ({bready, wvalid, wr_rdy} !== 3'b100) begin
      n_fail++; $display("FAIL w_resp got bready/wvalid/wr_rdy=%b want 100", {bready, wvalid, wr_rdy});
    end
    tick();
    n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL wr_wait_b got %b want 0", wr_rdy); end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    n_checks++; if ({wr_rdy, bready} !== 2'b10) begin
      n_fail++; $display("FAIL wr_done got wr_rdy/bready=%b want 10", {wr_rdy, bready});
    end
  endtask

  task automatic test_conflict();
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_2000; wr_data = {4{32'h5A5A_0000}};
    tick();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_2008;
    #1;
    n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL conf_aw got rd_rdy=%b want 0", rd_rdy); end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if ({rd_rdy, arvalid} !== 2'b00) begin
        n_fail++; $display("FAIL conf_w%0d got rd_rdy/arvalid=%b want 00", i, {rd_rdy, arvalid});
      end
      tick();
    end
    wready = 1'b0;
    bvalid = 1'b1;
    #1;
    n_checks++; if ({rd_rdy, arvalid} !== 2'b00) begin
      n_fail++; $display("FAIL conf_b got rd_rdy/arvalid=%b want 00", {rd_rdy, arvalid});
    end
    tick();
    bvalid = 1'b0;
    #1;
    n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL conf_release got %b want 1", rd_rdy); end
    tick();
    rd_req = 1'b0;
    #1;
    n_checks++; if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h0000_2008, 8'd0, 3'd2}) begin
      n_fail++; $display("FAIL conf_ar got v=%b a=%h l=%0d s=%0d want v=1 a=00002008 l=0 s=2",
                         arvalid, araddr, arlen, arsize);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0000_0055;
    #1;
    n_checks++; if ({ret_valid, ret_last, ret_data} !== {1'b1, 1'b1, 32'h55}) begin
      n_fail++; $display("FAIL conf_ret got v=%b l=%b d=%h want v=1 l=1 d=00000055", ret_valid, ret_last, ret_data);
    end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_concurrent();
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_3000; wr_data = {4{32'hC0C0_C0C0}};
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_3004;
    #1;
    n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL same_cycle_conf got %b want 0", rd_rdy); end
    rd_addr = 32'h0000_4000;
    #1;
    n_checks++; if ({rd_rdy, wr_rdy} !== 2'b11) begin
      n_fail++; $display("FAIL conc_accept got rd_rdy/wr_rdy=%b want 11", {rd_rdy, wr_rdy});
    end
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    n_checks++; if ({arvalid, awvalid, araddr, awaddr} !== {1'b1, 1'b1, 32'h0000_4000, 32'h0000_3000}) begin
      n_fail++; $display("FAIL conc_addr got arv=%b awv=%b ar=%h aw=%h want 1 1 00004000 00003000",
                         arvalid, awvalid, araddr, awaddr);
    end
    arready = 1'b1; awready = 1'b1;
    tick();
    arready = 1'b0; awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rlast = (i == 3); rdata = 32'hB0 + 32'(i);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_checks++; if ({rd_rdy, rready, wvalid, wr_rdy} !== 4'b1010) begin
      n_fail++; $display("FAIL conc_rd_done got rd_rdy/rready/wvalid/wr_rdy=%b want 1010",
                         {rd_rdy, rready, wvalid, wr_rdy});
    end
    wready = 1'b1;
    repeat (4) tick();
    wready = 1'b0;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL conc_wr_done got %b want 1", wr_rdy); end
  endtask

  task automatic test_word_write();
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_5004; wr_wstrb = 4'b0011;
    wr_data = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
    tick();
    wr_req = 1'b0;
    #1;
    n_checks++; if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h0000_5004, 8'd0, 3'd2}) begin
      n_fail++; $display("FAIL aw_word got v=%b a=%h l=%0d s=%0d want v=1 a=00005004 l=0 s=2",
                         awvalid, awaddr, awlen, awsize);
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready = 1'b1;
    #1;
    n_checks++; if ({wvalid, wlast, wstrb, wdata} !== {1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL w_word got v=%b l=%b s=%b d=%h want v=1 l=1 s=0011 d=deadbeef",
                         wvalid, wlast, wstrb, wdata);
    end
    tick();
    wready = 1'b0;
    #1;
    n_checks++; if ({wvalid, bready} !== 2'b01) begin
      n_fail++; $display("FAIL w_word_single got wvalid/bready=%b want 01", {wvalid, bready});
    end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_6000;
    tick();
    rd_req = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1; rlast = 1'b0;
    tick();
    rdata = 32'h2;
    rst = 1'b1;
    tick();
    rst = 1'b0; rvalid = 1'b0;
    #1;
    n_checks++; if ({rready, arvalid, ret_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_valids got rready/arvalid/ret_valid=%b want 000", {rready, arvalid, ret_valid});
    end
    n_checks++; if ({rd_rdy, wr_rdy} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_rdy got %b want 11", {rd_rdy, wr_rdy});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    rd_req = 1'b0; rd_type = 3'b000; rd_addr = '0;
    wr_req = 1'b0; wr_type = 3'b000; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    test_reset();
    test_line_read();
    test_line_write();
    test_conflict();
    test_concurrent();
    test_word_write();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Converts the cache's simple refill/writeback request interface (rd_req/ret_* and wr_req/wr_data) into AXI4 master transactions. Sits directly downstream of the cache: it accepts one line refill (4-beat INCR read) and one dirty-line writeback (4-beat INCR write) independently, and returns refill words beat-by-beat. A read that targets a line still being written back is held off until the write response returns.

## Interface
- ID_W, 4, AXI ID width
- RD_ID, 0, constant arid
- WR_ID, 1, constant awid
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- rd_req  in  1  refill/read request from cache
- rd_type  in  3  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 cache line
- rd_addr  in  32  read address (line-aligned for type 3'b100)
- rd_rdy  out  1  read request can be accepted this cycle
- ret_valid  out  1  returned word valid
- ret_last  out  1  last word of current read
- ret_data  out  32  returned word
- wr_req  in  1  writeback request
- wr_type  in  3  encoding as rd_type
- wr_addr  in  32  write address
- wr_wstrb  in  4  byte strobe (used only for non-line writes)
- wr_data  in  128  line data; word i = bits [32i+31:32i]
- wr_rdy  out  1  write request can be accepted this cycle
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  AXI AR channel
- arready  in  1
- rdata/rresp/rlast/rvalid  in  32/2/1/1  AXI R channel
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  AXI AW channel
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI W channel
- wready  in  1
- bresp/bvalid  in  2/1  AXI B channel
- bready  out  1

## Operation
- Read FSM: R_IDLE -> R_AR on rd_req&rd_rdy (latch addr/type); R_AR -> R_DATA on arvalid&arready; R_DATA -> R_IDLE on rvalid&rready&rlast.
- Write FSM: W_IDLE -> W_AW on wr_req&wr_rdy (latch addr/type/wstrb/data); W_AW -> W_DATA on awready; W_DATA -> W_RESP on wvalid&wready&wlast; W_RESP -> W_IDLE on bvalid.
- The two FSMs run concurrently; at most one read and one write outstanding.
- arvalid = (R_AR); rready = (R_DATA); awvalid = (W_AW); wvalid = (W_DATA); bready = (W_RESP).
- Line type (3'b100): len = 3, size = 3'b010, burst INCR, wstrb = 4'hf. Other types: len = 0, size = type[1:0], burst INCR, wstrb = latched wr_wstrb.
- Write beat counter (2 bits) resets to 0 on entering W_DATA and increments per W handshake; wdata = latched word[cnt]; wlast = (cnt == len[1:0]).
- ret_valid = rvalid & (R_DATA); ret_last = rlast; ret_data = rdata (combinational pass-through).
- wr_rdy = (W_IDLE).
- rd_rdy = (R_IDLE) & ~conflict. conflict = rd_addr[31:4] matches the latched write address [31:4] while write FSM ≠ W_IDLE, or matches wr_addr[31:4] while wr_req&wr_rdy in the same cycle.
- rresp/bresp ignored; no error signalling.

## Timing
- Reset: all FSMs idle; arvalid, rready, awvalid, wvalid, bready, ret_valid = 0; rd_rdy = 1 (absent conflict), wr_rdy = 1; beat counter 0.
- rd_req accepted in cycle T -> arvalid high from T+1, held with stable araddr until arready.
- First ret_valid is the cycle rvalid is seen in R_DATA; rd_rdy returns high the cycle after the rlast beat.
- wr_req accepted in T -> awvalid from T+1; wvalid from the cycle after the AW handshake; line write has 4 W beats minimum.
- wr_rdy returns high the cycle after the bvalid handshake.
- rst asserted mid-transaction: FSMs return to idle next edge; all valid/ready outputs drop; in-flight AXI beats are abandoned.
- AXI valid signals never deassert before their handshake.

## Test plan
- Line read 0x1C00_0040, arready after 2 cycles, 4 rdata beats 0xA0..0xA3 with gaps -> arlen=3, arsize=2, ret_valid on each beat, ret_last only with 0xA3, rd_rdy high the following cycle.
- Line write 0x0000_1230, data {0x33,0x22,0x11,0x00} -> awlen=3, wdata order 0x00,0x11,0x22,0x33, wlast on 4th, wr_rdy low until cycle after bvalid.
- Writeback of 0x0000_2000 then read of 0x0000_2008 before bvalid -> rd_rdy held 0, arvalid stays 0 until W_IDLE, then read proceeds.
- Concurrent writeback 0x3000 and read 0x4000 -> both AR and AW issued without waiting; read completes independently of B.
- Word write (type 3'b010, wstrb 4'b0011) -> awlen=0, awsize=2, single beat, wlast=1, wstrb=4'b0011.
- rst pulsed during read beat 2 -> rready, arvalid = 0 next cycle; rd_rdy=1, wr_rdy=1.
